serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/alu_pkg.sv | 18 +
 rtl/serial_adder_if.sv | 51 +++++
 rtl/full_adder_1b.sv | 13 +
 rtl/serial_adder.sv | 156 +++++++++++++++
 tb/tb_serial_adder.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and default sizing.
package alu_pkg;

  localparam int ALU_WIDTH          = 8;
  localparam int ALU_BITS_PER_CYCLE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // Number of RUN cycles needed to walk all operand bits.
  function automatic int alu_steps(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operation/result handshake bundle for serial_adder.
// Optional macro SERIAL_ADDER_FLAGS_EN adds output_zero and output_overflow.
interface serial_adder_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] output_sum;
  logic             output_carry;
`ifdef SERIAL_ADDER_FLAGS_EN
  logic             output_zero;
  logic             output_overflow;
`endif

`ifdef SERIAL_ADDER_FLAGS_EN
  // Producer of operations / consumer of results.
  modport master (
    output in_valid, input_a, input_b, sub, out_ready,
    input  in_ready, out_valid, output_sum, output_carry,
    input  output_zero, output_overflow
  );

  // The adder itself.
  modport slave (
    input  in_valid, input_a, input_b, sub, out_ready,
    output in_ready, out_valid, output_sum, output_carry,
    output output_zero, output_overflow
  );
`else
  // Producer of operations / consumer of results.
  modport master (
    output in_valid, input_a, input_b, sub, out_ready,
    input  in_ready, out_valid, output_sum, output_carry
  );

  // The adder itself.
  modport slave (
    input  in_valid, input_a, input_b, sub, out_ready,
    output in_ready, out_valid, output_sum, output_carry
  );
`endif

endinterface

// File: rtl/full_adder_1b.sv
// Single-bit full adder cell; chained to form the per-cycle ripple slice.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes BITS_PER_CYCLE bits per cycle,
// LSB chunk first, building the result in a right-shifting sum register.
// Optional macro SERIAL_ADDER_FLAGS_EN adds zero and signed-overflow outputs.
module serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH          = ALU_WIDTH,
  parameter int BITS_PER_CYCLE = ALU_BITS_PER_CYCLE
) (
  input logic         clk,
  input logic         rst,
  serial_adder_if.slave bus
);

  localparam int STEPS = alu_steps(WIDTH, BITS_PER_CYCLE);
  // Counter only has to reach STEPS-1; keep at least one bit.
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
  localparam logic [CNT_W-1:0] STEP_ONE  = CNT_W'(1);

  alu_state_t       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic [CNT_W-1:0] step_reg, step_next;
  // One-cycle hold-off after a result is taken, so a new operation cannot
  // be accepted in the same cycle the previous result retires.
  logic             drain_reg, drain_next;
`ifdef SERIAL_ADDER_FLAGS_EN
  logic             zero_reg, zero_next;
  logic             ovf_reg, ovf_next;
`endif

  logic                      in_ready;
  logic [BITS_PER_CYCLE:0]   chain;
  logic [BITS_PER_CYCLE-1:0] chunk;
  logic [WIDTH-1:0]          sum_shift;

  // Ripple slice: the running carry enters the lowest cell each cycle.
  assign chain[0] = carry_reg;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_fa
      full_adder_1b u_fa (
        .a    (a_reg[gi]),
        .b    (b_reg[gi]),
        .cin  (chain[gi]),
        .sum  (chunk[gi]),
        .cout (chain[gi+1])
      );
    end
  endgenerate

  // New chunk enters from the MSB side; after STEPS shifts the first chunk
  // has reached bit 0.
  generate
    if (BITS_PER_CYCLE == WIDTH) begin : g_shift_full
      assign sum_shift = chunk;
    end else begin : g_shift_part
      assign sum_shift = {chunk, sum_reg[WIDTH-1:BITS_PER_CYCLE]};
    end
  endgenerate

  assign in_ready = (state_reg == IDLE) && !drain_reg;

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    step_next  = step_reg;
    drain_next = 1'b0;
`ifdef SERIAL_ADDER_FLAGS_EN
    zero_next  = zero_reg;
    ovf_next   = ovf_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          a_next     = bus.input_a;
          b_next     = bus.sub ? ~bus.input_b : bus.input_b;
          carry_next = bus.sub;
          step_next  = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        a_next     = a_reg >> BITS_PER_CYCLE;
        b_next     = b_reg >> BITS_PER_CYCLE;
        sum_next   = sum_shift;
        carry_next = chain[BITS_PER_CYCLE];
        step_next  = step_reg + STEP_ONE;
        if (step_reg == LAST_STEP) begin
          state_next = DONE;
`ifdef SERIAL_ADDER_FLAGS_EN
          // Signed overflow: carry into the MSB cell differs from carry out.
          ovf_next   = chain[BITS_PER_CYCLE] ^ chain[BITS_PER_CYCLE-1];
          zero_next  = (sum_shift == '0);
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
          drain_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      step_reg  <= '0;
      drain_reg <= 1'b0;
`ifdef SERIAL_ADDER_FLAGS_EN
      zero_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      step_reg  <= step_next;
      drain_reg <= drain_next;
`ifdef SERIAL_ADDER_FLAGS_EN
      zero_reg  <= zero_next;
      ovf_reg   <= ovf_next;
`endif
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = (state_reg == DONE);
  assign bus.output_sum   = sum_reg;
  assign bus.output_carry = carry_reg;
`ifdef SERIAL_ADDER_FLAGS_EN
  assign bus.output_zero     = zero_reg;
  assign bus.output_overflow = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8/BPC=1 and WIDTH=16/BPC=4
// instances, directed vector table, hand-written corner sequences and a
// randomized regression against an arithmetic reference model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(16)) bus16 ();

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          sel;   // 0: 8-bit instance, 1: 16-bit instance
    logic [15:0] a;
    logic [15:0] b;
    bit          s;
    logic [15:0] sum;
    bit          c;
    bit          z;
    bit          o;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int width_of(input int sel);
    return (sel == 0) ? 8 : 16;
  endfunction

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 8 : 4;
  endfunction

  function automatic logic get_in_ready(input int sel);
    return (sel == 0) ? bus8.in_ready : bus16.in_ready;
  endfunction

  function automatic logic get_out_valid(input int sel);
    return (sel == 0) ? bus8.out_valid : bus16.out_valid;
  endfunction

  function automatic logic [15:0] get_sum(input int sel);
    return (sel == 0) ? {8'h00, bus8.output_sum} : bus16.output_sum;
  endfunction

  function automatic logic get_carry(input int sel);
    return (sel == 0) ? bus8.output_carry : bus16.output_carry;
  endfunction

`ifdef SERIAL_ADDER_FLAGS_EN
  function automatic logic get_zero(input int sel);
    return (sel == 0) ? bus8.output_zero : bus16.output_zero;
  endfunction

  function automatic logic get_ovf(input int sel);
    return (sel == 0) ? bus8.output_overflow : bus16.output_overflow;
  endfunction
`endif

  task automatic drive_in(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input bit s, input bit v);
    if (sel == 0) begin
      bus8.in_valid = v;
      bus8.input_a  = a[7:0];
      bus8.input_b  = b[7:0];
      bus8.sub      = s;
    end else begin
      bus16.in_valid = v;
      bus16.input_a  = a;
      bus16.input_b  = b;
      bus16.sub      = s;
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic ref_op(input int w, input logic [15:0] a, input logic [15:0] b, input bit s,
                        output logic [15:0] sum, output bit c, output bit z, output bit o);
    longint m, ua, ub, full, sa, sb, sr;
    m  = 64'sd1 <<< w;
    ua = longint'(a) % m;
    ub = longint'(b) % m;
    if (s) begin
      full = ua - ub;
      c    = (ua >= ub);
    end else begin
      full = ua + ub;
      c    = (full >= m);
    end
    sum = 16'(((full % m) + m) % m);
    z   = (sum == 16'h0);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sb  = (ub >= m / 2) ? ub - m : ub;
    sr  = s ? sa - sb : sa + sb;
    o   = (sr >= m / 2) || (sr < -(m / 2));
  endtask

  // Issue one operation (operands change to garbage right after the accept
  // edge), wait for the result and compare everything against expectations.
  task automatic run_op(input string tag, input int sel, input logic [15:0] a,
                        input logic [15:0] b, input bit s, input logic [15:0] e_sum,
                        input bit e_c, input bit e_z, input bit e_o);
    int k;
    int lat;
    k = 0;
    while (!get_in_ready(sel) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, " in_ready"}, longint'(get_in_ready(sel)), 1);
    drive_in(sel, a, b, s, 1'b1);
    @(negedge clk);
    drive_in(sel, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    lat = 0;
    while (!get_out_valid(sel) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, lat_of(sel));
    check({tag, " sum"}, longint'(get_sum(sel)), longint'(e_sum));
    check({tag, " carry"}, longint'(get_carry(sel)), longint'(e_c));
`ifdef SERIAL_ADDER_FLAGS_EN
    check({tag, " zero"}, longint'(get_zero(sel)), longint'(e_z));
    check({tag, " overflow"}, longint'(get_ovf(sel)), longint'(e_o));
`else
    if (e_z && e_o) begin end
`endif
    // out_ready is high, so the result retires at the next edge; the
    // following cycle must still refuse a new operation.
    @(negedge clk);
    check({tag, " holdoff"}, longint'({get_out_valid(sel), get_in_ready(sel)}), 0);
    $display("%s: sel=%0d a=%h b=%h sub=%0d sum=%h carry=%0d lat=%0d",
             tag, sel, a, b, s, e_sum, e_c, lat);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r_sum;
    bit          r_c, r_z, r_o;
    int          seen;

    vecs[0] = '{0, 16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{0, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{0, 16'h0005, 16'h0007, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{0, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{0, 16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1, 16'h1234, 16'hEDCC, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    drive_in(0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive_in(1, 16'h0, 16'h0, 1'b0, 1'b0);
    bus8.out_ready  = 1'b1;
    bus16.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state of both instances.
    for (int sel = 0; sel < 2; sel++) begin
      check($sformatf("reset%0d in_ready", sel), longint'(get_in_ready(sel)), 1);
      check($sformatf("reset%0d out_valid", sel), longint'(get_out_valid(sel)), 0);
      check($sformatf("reset%0d sum", sel), longint'(get_sum(sel)), 0);
      check($sformatf("reset%0d carry", sel), longint'(get_carry(sel)), 0);
`ifdef SERIAL_ADDER_FLAGS_EN
      check($sformatf("reset%0d flags", sel), longint'({get_zero(sel), get_ovf(sel)}), 0);
`endif
    end

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].s,
             vecs[i].sum, vecs[i].c, vecs[i].z, vecs[i].o);
    end

    // Back-pressure in DONE, with input noise during RUN.
    bus8.out_ready = 1'b0;
    drive_in(0, 16'h003C, 16'h0055, 1'b0, 1'b1);
    @(negedge clk);
    seen = 0;
    while (!bus8.out_valid && seen < 100) begin
      drive_in(0, 16'($urandom), 16'($urandom), 1'($urandom), seen[0]);
      @(negedge clk);
      seen++;
    end
    drive_in(0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("bp latency", seen, 8);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d sum", k), longint'(bus8.output_sum), 'h91);
      check($sformatf("bp hold%0d carry", k), longint'(bus8.output_carry), 0);
      check($sformatf("bp hold%0d valid/ready", k),
            longint'({bus8.out_valid, bus8.in_ready}), 'b10);
`ifdef SERIAL_ADDER_FLAGS_EN
      check($sformatf("bp hold%0d flags", k),
            longint'({bus8.output_zero, bus8.output_overflow}), 'b01);
`endif
    end
    bus8.out_ready = 1'b1;
    @(negedge clk);
    check("bp retire", longint'({bus8.out_valid, bus8.in_ready}), 0);
    @(negedge clk);
    check("bp reissue", longint'(bus8.in_ready), 1);
    $display("backpressure: 3c+55 held 5 cycles");

    // Reset in the middle of RUN.
    drive_in(0, 16'h00AA, 16'h0011, 1'b0, 1'b1);
    @(negedge clk);
    drive_in(0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst in_ready", longint'(bus8.in_ready), 1);
    check("rst out_valid", longint'(bus8.out_valid), 0);
    check("rst sum", longint'(bus8.output_sum), 0);
    check("rst carry", longint'(bus8.output_carry), 0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus8.out_valid) seen++;
    end
    check("rst no out_valid", seen, 0);
    $display("reset mid-run: operation abandoned");
    run_op("after rst", 0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    // Randomized regression on both instances.
    for (int sel = 0; sel < 2; sel++) begin
      for (int i = 0; i < 1000; i++) begin
        logic [15:0] ra, rb;
        bit          rs;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rs = 1'($urandom);
        if (sel == 0) begin
          ra[15:8] = 8'h00;
          rb[15:8] = 8'h00;
        end
        ref_op(width_of(sel), ra, rb, rs, r_sum, r_c, r_z, r_o);
        run_op($sformatf("rand%0d_%0d", sel, i), sel, ra, rb, rs, r_sum, r_c, r_z, r_o);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
